// File: rtl/clkdiv_prog.sv
// clkdiv_prog: multi-channel programmable divide-by-N clock generator.
// Every channel counts off clkin, so all outputs stay phase-related.
//
// Ports:
//   clkin      source clock, all state on its rising edge
//   rst        asynchronous active-high reset
//   en         per-channel run enable (level)
//   sync       one-cycle pulse, restarts enabled channels at phase 0
//   cfg_valid  ratio update request
//   cfg_ready  update can be taken for cfg_chan (no ratio pending there)
//   cfg_chan   target channel of the update
//   cfg_div    requested ratio N (0 and 1 are stored as 2)
//   clkout     registered divided clocks
//   tick       one-cycle pulse in the first cycle of each output period
module clkdiv_prog #(
    parameter int CHANNELS    = 4,
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 4,
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clkin,
    input  logic                rst,
    input  logic [CHANNELS-1:0] en,
    input  logic                sync,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CW-1:0]       cfg_chan,
    input  logic [DIV_W-1:0]    cfg_div,
    output logic [CHANNELS-1:0] clkout,
    output logic [CHANNELS-1:0] tick
);

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } st_t;

    logic [CHANNELS-1:0] pend;
    logic                xfer;
    logic [DIV_W-1:0]    cfg_div_c;

    // A channel index beyond CHANNELS has no pending flag, so the
    // transfer is always taken and simply lands nowhere.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
            if (int'(cfg_chan) == i) begin
                cfg_ready = !pend[i];
            end
        end
    end

    assign xfer      = cfg_valid && cfg_ready;
    assign cfg_div_c = (cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg_div;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        st_t              st_q;
        st_t              st_d;
        logic [DIV_W-1:0] cnt_q;
        logic [DIV_W-1:0] cnt_d;
        logic [DIV_W-1:0] div_q;
        logic [DIV_W-1:0] div_d;
        logic [DIV_W-1:0] pdiv_q;
        logic [DIV_W-1:0] pdiv_d;
        logic             pend_q;
        logic             pend_d;
        logic             clk_q;
        logic             clk_d;
        logic             tick_q;
        logic             tick_d;
        logic             acc;
        logic             bnd;
        logic             apply;
        logic [DIV_W:0]   half_d;

        assign acc = xfer && (int'(cfg_chan) == i);
        assign bnd = (st_q != OFF) && (cnt_q == div_q - 1'b1);

        // Next-state logic. sync outranks the period boundary; a pending
        // ratio is applied at sync, at a boundary, or straight away in OFF.
        always_comb begin
            st_d  = st_q;
            cnt_d = cnt_q;
            apply = 1'b0;
            if (sync) begin
                st_d  = en[i] ? RUN : OFF;
                cnt_d = '0;
                apply = pend_q;
            end else begin
                unique case (st_q)
                    OFF: begin
                        apply = pend_q;
                        if (en[i]) begin
                            st_d = RUN;
                        end
                    end
                    RUN, DRAIN: begin
                        if (bnd) begin
                            cnt_d = '0;
                            apply = pend_q;
                            st_d  = en[i] ? RUN : OFF;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                            st_d  = en[i] ? RUN : DRAIN;
                        end
                    end
                    default: begin
                        st_d  = OFF;
                        cnt_d = '0;
                    end
                endcase
            end
        end

        // acc only fires with pend_q low and apply only with pend_q high,
        // so an update taken this cycle always waits for a later edge.
        always_comb begin
            div_d  = apply ? pdiv_q : div_q;
            pdiv_d = acc ? cfg_div_c : pdiv_q;
            pend_d = (pend_q && !apply) || acc;
        end

        // Outputs are computed from next state so they can be registered
        // and still line up with the counter.
        always_comb begin
            half_d = ({1'b0, div_d} + 1'b1) >> 1;
            clk_d  = (st_d != OFF) && ({1'b0, cnt_d} < half_d);
            tick_d = (st_d != OFF) && (cnt_d == '0);
        end

        always_ff @(posedge clkin or posedge rst) begin
            if (rst) begin
                st_q   <= OFF;
                cnt_q  <= '0;
                div_q  <= DIV_W'(DEFAULT_DIV);
                pdiv_q <= DIV_W'(DEFAULT_DIV);
                pend_q <= 1'b0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                st_q   <= st_d;
                cnt_q  <= cnt_d;
                div_q  <= div_d;
                pdiv_q <= pdiv_d;
                pend_q <= pend_d;
                clk_q  <= clk_d;
                tick_q <= tick_d;
            end
        end

        assign pend[i]   = pend_q;
        assign clkout[i] = clk_q;
        assign tick[i]   = tick_q;
    end

endmodule

// File: doc/clkdiv_prog.md
# clkdiv_prog

Multi-channel programmable synchronous clock divider, successor to the fixed ripple divide-by-2^n chain. Every channel runs a divide-by-N counter off the single input clock, so all outputs are phase-related and ripple-free. Each channel has a run-time-programmable ratio, odd or even, applied glitch-free at period boundaries, plus a per-channel enable with clean stop. A global sync pulse phase-aligns all channels. It feeds the link clock tree and sideband timing.

## Interface
- CHANNELS, 4, number of independent divided outputs (1..16).
- DIV_W, 8, ratio register width; ratio range 2..2^DIV_W-1.
- DEFAULT_DIV, 4, ratio loaded into every channel at reset (must be ≥2).
- clkin  input  1  source clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  CHANNELS  per-channel run enable, level-sensitive.
- sync  input  1  single-cycle pulse; restart all enabled channels at phase 0.
- cfg_valid  input  1  ratio update request.
- cfg_ready  output  1  update can be accepted for cfg_chan.
- cfg_chan  input  $clog2(CHANNELS) (min 1)  target channel.
- cfg_div  input  DIV_W  new ratio N.
- clkout  output  CHANNELS  divided clocks, registered.
- tick  output  CHANNELS  one-cycle pulse, high in the first cycle of each output period.

## Operation
- Per channel: ratio register div, pending register pdiv plus pend flag, counter cnt (DIV_W bits), state OFF/RUN/DRAIN.
- Ratio clamp: cfg_div of 0 or 1 is stored as 2.
- Waveform in RUN/DRAIN: period N cycles, cnt counts 0..N-1. clkout is high for cnt < ceil(N/2) and low otherwise. Odd N gives high for (N+1)/2 cycles and low for (N-1)/2. tick is high iff cnt==0.
- Boundary: the cycle with cnt==N-1.
- OFF → RUN: en[i] sampled high. Next cycle cnt=0, clkout=1, tick=1.
- RUN → DRAIN: en[i] sampled low. The current period completes unchanged.
- DRAIN → RUN: en[i] sampled high again before the boundary. No disturbance to the waveform.
- DRAIN → OFF: at the boundary. clkout=0, tick=0, cnt=0.
- Config handshake: transfer occurs when cfg_valid && cfg_ready. cfg_ready = !pend[cfg_chan] (combinational from cfg_chan). If cfg_chan ≥ CHANNELS, cfg_ready=1 and the transfer is accepted and discarded.
- An accepted ratio is written to pdiv and sets pend. It is applied as follows:
  - RUN/DRAIN: at the boundary, so the next period uses the new N.
  - OFF: on the next edge.
  - On sync: see below.
  - Applying the ratio clears pend.
- sync sampled high:
  - Every channel with en high: next cycle cnt=0, clkout=1, tick=1, state RUN. This includes channels that are OFF or in DRAIN.
  - Every channel with en low: forced OFF.
  - Pending ratios are applied.
  - sync is intentionally phase-disruptive and may shorten a period.
- Simultaneous events:
  - sync has priority over the boundary.
  - A transfer accepted in the boundary cycle is not applied at that boundary; it is applied at the following one.
  - For a channel in OFF with en rising in the same cycle as a transfer, the channel starts with the old div. The new ratio is applied at the first boundary.

## Timing
- Reset (async assert, deassert synchronous to clkin):
  - All channels OFF, cnt=0, div=DEFAULT_DIV, pend=0.
  - clkout=0, tick=0, cfg_ready=1.
- Output latency: 1 cycle from sampled en/sync to the first tick/clkout high.
- Ratio latency: the new N takes effect at the first boundary after the accept edge.
- Reset mid-period: outputs go to 0 immediately. No pending update survives.
- No combinational path from en/sync/cfg to clkout/tick.

## Test plan
- Reset, then en=0001, N=4 default → clkout[0]=1100 repeating, tick[0] every 4th cycle starting 1 cycle after en; other channels 0.
- Write N=5 to ch0 mid-period → current period stays 4 cycles, next periods are 11100; cfg_ready low until applied; a second write while pending stalls.
- cfg_div=0 and cfg_div=1 → behave as N=2 (1010); cfg_chan=CHANNELS (when not a power of two) → accepted, no effect.
- en[1] drops at cnt=1 with N=6 → period completes (111000), then clkout[1]=0; re-raising en at cnt=4 instead → no gap.
- Channels at N=3, 4, 7 free-running, pulse sync → all tick together 1 cycle later; a channel with en low goes OFF immediately.
- Assert rst mid-period with a pending update → outputs 0 asynchronously; after release and en, N=DEFAULT_DIV.
